// File: rtl/para_to_seq_out.sv
// para_to_seq_out: captures one RSA_LEN-bit result on a load strobe and
// streams it out least-significant word first as RSA_LEN/BUS_W words of
// BUS_W bits over a valid/ready handshake.
module para_to_seq_out #(
    parameter int unsigned RSA_LEN = 512,
    parameter int unsigned BUS_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [RSA_LEN-1:0] data_in,
    input  logic               out_rdy,
    output logic [BUS_W-1:0]   data_out,
    output logic               vld,
    output logic               last,
    output logic [4:0]         idx,
    output logic               busy,
    output logic               done,
    output logic               ovf
);

    localparam int unsigned NWORDS   = RSA_LEN / BUS_W;
    localparam logic [4:0]  LAST_IDX = 5'(NWORDS - 1);

    // Reject geometries the 5-bit word index cannot address.
    if ((RSA_LEN % BUS_W) != 0 || NWORDS < 2 || NWORDS > 32) begin : g_bad_params
        $error("para_to_seq_out: RSA_LEN must be BUS_W * (2..32)");
    end

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [RSA_LEN-1:0] sreg;

    // The shift register is shifted on every accepted word, including the
    // final one, so it is all-zero whenever the block is idle. That lets
    // data_out come straight from the register and still read 0 when vld=0.
    assign data_out = sreg[BUS_W-1:0];
    assign busy     = vld;

    // Serializer FSM: capture, shift out on handshake, flag loads while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
            vld   <= 1'b0;
            last  <= 1'b0;
            done  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= SEND;
                        sreg  <= data_in;
                        idx   <= '0;
                        vld   <= 1'b1;
                        last  <= 1'b0;
                    end
                end
                SEND: begin
                    if (load) begin
                        ovf <= 1'b1;
                    end
                    if (out_rdy) begin
                        sreg <= sreg >> BUS_W;
                        if (last) begin
                            state <= IDLE;
                            vld   <= 1'b0;
                            last  <= 1'b0;
                            idx   <= '0;
                            done  <= 1'b1;
                        end else begin
                            idx  <= idx + 5'd1;
                            last <= ((idx + 5'd1) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_para_to_seq_out.sv
// tb_para_to_seq_out: directed stimulus with a per-cycle reference model,
// a loopback reassembler and a few literal expectations.
module tb_para_to_seq_out;

    localparam int RSA_LEN = 512;
    localparam int BUS_W   = 32;
    localparam int NW      = RSA_LEN / BUS_W;

    logic               clk;
    logic               rst;
    logic               load;
    logic [RSA_LEN-1:0] data_in;
    logic               out_rdy;
    logic [BUS_W-1:0]   data_out;
    logic               vld;
    logic               last;
    logic [4:0]         idx;
    logic               busy;
    logic               done;
    logic               ovf;

    para_to_seq_out #(
        .RSA_LEN(RSA_LEN),
        .BUS_W  (BUS_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .data_in (data_in),
        .out_rdy (out_rdy),
        .data_out(data_out),
        .vld     (vld),
        .last    (last),
        .idx     (idx),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [RSA_LEN-1:0] act,
                         input logic [RSA_LEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the captured value, which word is on offer, and flags.
    logic [RSA_LEN-1:0] m_val  = '0;
    int                 m_k    = 0;
    bit                 m_busy = 0;
    bit                 m_done = 0;
    bit                 m_ovf  = 0;

    // Advance the model on each rising edge using the inputs held this cycle.
    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0;
            m_k    = 0;
            m_done = 0;
            m_ovf  = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                if (load) m_ovf = 1;
                if (out_rdy) begin
                    if (m_k == NW - 1) begin
                        m_busy = 0;
                        m_k    = 0;
                        m_done = 1;
                    end else begin
                        m_k = m_k + 1;
                    end
                end
            end else if (load) begin
                m_busy = 1;
                m_val  = data_in;
                m_k    = 0;
            end
        end
    end

    logic [RSA_LEN-1:0] asm_val = '0;
    int acc_cnt  = 0;
    int done_cnt = 0;
    int lb_cnt   = 0;

    // Compare every output against the model mid-cycle; reassemble the stream.
    always @(negedge clk) begin
        logic [BUS_W-1:0] exp_word;
        exp_word = m_busy ? m_val[m_k*BUS_W +: BUS_W] : '0;
        check("vld",      vld,      m_busy);
        check("busy",     busy,     m_busy);
        check("data_out", data_out, exp_word);
        check("last",     last,     m_busy && (m_k == NW - 1));
        check("idx",      idx,      m_busy ? m_k : 0);
        check("done",     done,     m_done);
        check("ovf",      ovf,      m_ovf);
        if (done) done_cnt++;
        if (!rst && vld && out_rdy) begin
            acc_cnt++;
            asm_val[idx*BUS_W +: BUS_W] = data_out;
            if (last) begin
                lb_cnt++;
                check("loopback", asm_val, m_val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [RSA_LEN-1:0] counting();
        logic [RSA_LEN-1:0] v;
        for (int k = 0; k < NW; k++) v[k*BUS_W +: BUS_W] = BUS_W'(k);
        return v;
    endfunction

    function automatic logic [RSA_LEN-1:0] rand_val();
        logic [RSA_LEN-1:0] v;
        for (int k = 0; k < NW; k++) v[k*BUS_W +: BUS_W] = $urandom;
        return v;
    endfunction

    logic [RSA_LEN-1:0] c_val;

    initial begin
        rst     = 1'b1;
        load    = 1'b0;
        out_rdy = 1'b0;
        data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_vld",  vld,      1'b0);
        check("rst_data", data_out, '0);

        // Full-rate stream of word k = k.
        data_in = counting();
        load    = 1'b1;
        out_rdy = 1'b1;
        tick();
        load = 1'b0;
        check("lit_word0", data_out, 0);
        check("lit_idx0",  idx,      0);
        for (int k = 1; k < NW; k++) begin
            tick();
            check("lit_word", data_out, k);
            check("lit_last", last,     k == NW - 1);
        end
        tick();
        check("lit_done", done, 1'b1);
        check("lit_vld",  vld,  1'b0);
        check("lit_ovf0", ovf,  1'b0);

        // Backpressure 1,0,0,1 with data_in changed after capture.
        tick();
        data_in = counting();
        load    = 1'b1;
        tick();
        load     = 1'b0;
        data_in  = '1;
        acc_cnt  = 0;
        done_cnt = 0;
        for (int p = 0; p < 34; p++) begin
            out_rdy = (p % 4 == 0) || (p % 4 == 3);
            tick();
        end
        check("bp_accepts", acc_cnt,  16);
        check("bp_dones",   done_cnt, 1);

        // Overflow: loads at word 5 and at the final handshake are ignored.
        out_rdy = 1'b1;
        data_in = rand_val();
        load    = 1'b1;
        tick();
        for (int j = 0; j < NW; j++) begin
            load    = (j == 5) || (j == NW - 1);
            data_in = '1;
            tick();
        end
        check("ov_done", done, 1'b1);
        check("ov_flag", ovf,  1'b1);
        c_val   = rand_val();
        data_in = c_val;
        load    = 1'b1;
        tick();
        load = 1'b0;
        check("ov_restart_word", data_out, c_val[BUS_W-1:0]);
        check("ov_restart_idx",  idx,      0);
        check("ov_sticky",       ovf,      1'b1);
        repeat (NW + 1) tick();

        // Reset mid-stream.
        data_in = rand_val();
        load    = 1'b1;
        tick();
        load = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("mr_vld",  vld,      1'b0);
        check("mr_data", data_out, '0);
        check("mr_ovf",  ovf,      1'b0);
        check("mr_done", done,     1'b0);
        tick();
        check("mr_nodone", done, 1'b0);

        // Loopback of random values at the minimum back-to-back period.
        done_cnt = 0;
        lb_cnt   = 0;
        for (int n = 0; n < 100; n++) begin
            data_in = rand_val();
            load    = 1'b1;
            tick();
            load = 1'b0;
            repeat (NW) tick();
        end
        tick();
        tick();
        check("lb_dones",  done_cnt, 100);
        check("lb_count",  lb_cnt,   100);
        check("lb_noovf",  ovf,      1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/para_to_seq_out.md
# para_to_seq_out

Result serializer for the RSA datapath. It captures one RSA_LEN-bit parallel result from the modular-exponentiation core on a single-cycle load strobe. It then emits the result as RSA_LEN/BUS_W words of BUS_W bits over a valid/ready handshake to the host-bus read side. Word order is least-significant word first, so feeding its output stream into the input deserializer reproduces the original operand bit-exactly.

## Interface
- RSA_LEN, 512, width of the parallel result; must be a multiple of BUS_W.
- BUS_W, 32, output word width.
- NWORDS (derived, not overridable), RSA_LEN/BUS_W = 16; legal range 2..32.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- load  input  1  one-cycle strobe; data_in is captured when the block is idle.
- data_in  input  RSA_LEN  parallel result from the core.
- out_rdy  input  1  consumer accepts the current word when vld=1.
- data_out  output  BUS_W  current word; 0 whenever vld=0.
- vld  output  1  data_out holds a valid word.
- last  output  1  the current valid word is word NWORDS-1; only ever high together with vld.
- idx  output  5  index of the current word, 0..NWORDS-1; 0 when idle.
- busy  output  1  a result is being streamed; load is not accepted.
- done  output  1  one-cycle pulse after the final word is accepted.
- ovf  output  1  sticky error: a load arrived while busy.

## Operation
- States:
  - IDLE: busy=0, vld=0.
  - SEND: busy=1, vld=1.
- IDLE -> SEND:
  - Trigger: load=1.
  - Actions: shift register <= data_in; idx <= 0.
- In SEND, word idx is data_in[BUS_W*idx +: BUS_W], taken from the captured copy. Later changes to data_in have no effect.
- Handshake: a word transfers in any cycle with vld=1 and out_rdy=1.
  - Not the final word: shift register moves right by BUS_W and idx increments by 1.
  - Final word (idx=NWORDS-1, last=1): state -> IDLE and done=1 in the following cycle.
- While vld=1 and out_rdy=0, data_out, idx and last hold stable. There is no timeout.
- Load while busy:
  - The load is ignored and the captured data is not disturbed.
  - ovf <= 1. ovf stays set until rst; an accepted load does not clear it.
- Load in the same cycle as the final handshake: the block is still busy, so the load is ignored and ovf is set.
- Load in the done cycle: the block is IDLE, so the load is accepted normally.
- idx is a 5-bit counter compared against NWORDS-1; it never wraps past NWORDS-1.

## Timing
- Reset values: data_out=0, vld=0, last=0, idx=0, busy=0, done=0, ovf=0. The shift register clears to 0.
- rst mid-stream: all outputs take their reset values after the edge. The partially sent result is discarded and no done pulse is generated.
- Load latency: load sampled at edge t; vld=1 with word 0 from edge t+1.
- Throughput: with out_rdy held high, one word per cycle. NWORDS words occupy cycles t+1..t+NWORDS, done=1 in cycle t+NWORDS+1, and the next load is accepted in that same cycle.
- Back-to-back minimum period: NWORDS+1 cycles per result.
- last is high exactly in the cycle(s) in which word NWORDS-1 is presented.
- busy = vld in every cycle.

## Test plan
- **Reset:** assert rst for 2 cycles mid-stream -> all outputs 0 next cycle; no done; new load accepted afterwards.
- **Full-rate stream:** load data_in = {16 words 0x0F..0x00} (word k = k), out_rdy=1 -> data_out 0x00..0x0F in consecutive cycles, last only on 0x0F, done one cycle later, ovf=0.
- **Backpressure:** same load, out_rdy pattern 1,0,0,1 repeating -> each word held stable while out_rdy=0, idx sequence unbroken, done after the 16th accepted word.
- **Overflow:**
  - load at word 5 -> ovf=1 permanently; words 5..15 unchanged.
  - second load in the cycle of the final handshake -> ignored.
  - load in the done cycle -> accepted, stream restarts at word 0.
- **Input isolation:** change data_in to all-ones after capture -> output words still equal the captured values.
- **Loopback:** drive output into the input deserializer with out_rdy=1, random 512-bit values x100 -> reassembled value equals data_in.
